// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the signed ALU sub-units: decode, issue, wait
// for the unit flag (with watchdog) and return the result.
module alu_cmd_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 32,
    parameter int TIMEOUT    = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_fun,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    output logic [1:0]            ALU_FUN,
    output logic                  Arith_Enable,
    output logic                  Logic_Enable,
    output logic                  CMP_Enable,
    output logic                  Shift_Enable,
    input  logic [OUT_WIDTH-1:0]  Arith_OUT,
    input  logic [DATA_WIDTH-1:0] Logic_OUT,
    input  logic [1:0]            CMP_OUT,
    input  logic [DATA_WIDTH-1:0] Shift_OUT,
    input  logic                  Arith_Flag,
    input  logic                  Logic_Flag,
    input  logic                  CMP_Flag,
    input  logic                  Shift_Flag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [OUT_WIDTH-1:0]  rsp_data,
    output logic [1:0]            rsp_unit,
    output logic                  rsp_timeout
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t               state, state_n;
    logic [1:0]           unit;
    logic [7:0]           cnt;
    logic [3:0]           en;
    logic                 flag_sel;
    logic [OUT_WIDTH-1:0] res_sel;
    logic                 accept, hit, expire;

    assign cmd_ready    = (state == IDLE);
    assign rsp_valid    = (state == RESP);
    assign accept       = cmd_ready && cmd_valid;
    assign Arith_Enable = en[0];
    assign Logic_Enable = en[1];
    assign CMP_Enable   = en[2];
    assign Shift_Enable = en[3];

    always_comb begin
        flag_sel = 1'b0;
        res_sel  = '0;
        unique case (unit)
            2'd0: begin flag_sel = Arith_Flag; res_sel = Arith_OUT; end
            2'd1: begin flag_sel = Logic_Flag; res_sel = OUT_WIDTH'(Logic_OUT); end
            2'd2: begin flag_sel = CMP_Flag;   res_sel = OUT_WIDTH'(CMP_OUT); end
            2'd3: begin flag_sel = Shift_Flag; res_sel = OUT_WIDTH'(Shift_OUT); end
            default: ;
        endcase
    end

    // First WAIT cycle (cnt == 0) ignores the flag to reject stale results
    assign hit    = (state == WAIT) && (cnt != 8'd0) && flag_sel;
    assign expire = (state == WAIT) && (cnt == LAST) && !hit;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept) state_n = WAIT;
            WAIT:    if (hit || expire) state_n = RESP;
            RESP:    if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            A           <= '0;
            B           <= '0;
            ALU_FUN     <= '0;
            unit        <= '0;
            cnt         <= '0;
            en          <= '0;
            rsp_data    <= '0;
            rsp_unit    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                A       <= cmd_a;
                B       <= cmd_b;
                ALU_FUN <= cmd_fun[1:0];
                unit    <= cmd_fun[3:2];
                en      <= 4'b0001 << cmd_fun[3:2];
                cnt     <= '0;
            end
            if (state == WAIT) begin
                cnt <= cnt + 8'd1;
                if (hit) begin
                    en          <= '0;
                    rsp_data    <= res_sel;
                    rsp_unit    <= unit;
                    rsp_timeout <= 1'b0;
                end else if (expire) begin
                    en          <= '0;
                    rsp_data    <= '0;
                    rsp_unit    <= unit;
                    rsp_timeout <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer.
module tb_alu_cmd_sequencer;
    logic        CLK = 1'b0;
    logic        RST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_fun;
    logic [15:0] cmd_a, cmd_b;
    logic [15:0] A, B;
    logic [1:0]  ALU_FUN;
    logic        Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
    logic [31:0] Arith_OUT;
    logic [15:0] Logic_OUT, Shift_OUT;
    logic [1:0]  CMP_OUT;
    logic        Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_unit;
    logic        rsp_timeout;
    logic [3:0]  ens;

    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    assign ens = {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable};

    alu_cmd_sequencer #(.DATA_WIDTH(16), .OUT_WIDTH(32), .TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fun(cmd_fun),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .A(A), .B(B), .ALU_FUN(ALU_FUN),
        .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
        .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
        .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT),
        .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
        .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
        .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_unit(rsp_unit), .rsp_timeout(rsp_timeout)
    );

    // Inputs change and outputs are checked at the falling edge
    task automatic step();
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        cmd_valid = 1'b1;
        cmd_fun   = f;
        cmd_a     = a;
        cmd_b     = b;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        RST = 1'b1; cmd_valid = 1'b1; cmd_fun = 4'b1010;
        cmd_a = 16'd7; cmd_b = 16'd9; rsp_ready = 1'b1;
        Arith_OUT = '0; Logic_OUT = '0; Shift_OUT = '0; CMP_OUT = '0;
        Arith_Flag = 0; Logic_Flag = 0; CMP_Flag = 0; Shift_Flag = 0;
        step();
        step();
        chk("rst_ready", cmd_ready, 1);
        chk("rst_en", ens, 0);
        chk("rst_valid", rsp_valid, 0);
        RST = 1'b0; cmd_valid = 1'b0;
        step();
        chk("rst_a", A, 0);
        chk("rst_fun", ALU_FUN, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_unit", rsp_unit, 0);
        chk("rst_tmo", rsp_timeout, 0);
        chk("rst_idle_ready", cmd_ready, 1);

        // compare, flag one cycle after enable
        issue(4'b1010, 16'd5, 16'd3);
        chk("cmp_en0", ens, 4'b0100);
        chk("cmp_a", A, 5);
        chk("cmp_b", B, 3);
        chk("cmp_fun", ALU_FUN, 2);
        chk("cmp_busy", cmd_ready, 0);
        step();
        chk("cmp_en1", ens, 4'b0100);
        chk("cmp_nv1", rsp_valid, 0);
        CMP_OUT = 2'd2; CMP_Flag = 1'b1;
        step();
        CMP_Flag = 1'b0;
        chk("cmp_en2", ens, 0);
        chk("cmp_valid", rsp_valid, 1);
        chk("cmp_data", rsp_data, 2);
        chk("cmp_unit", rsp_unit, 2);
        chk("cmp_tmo", rsp_timeout, 0);
        step();
        chk("cmp_done", rsp_valid, 0);
        chk("cmp_ready", cmd_ready, 1);

        // signed compare with stale flag in first WAIT cycle
        issue(4'b1011, 16'hFFFC, 16'd1);
        chk("scmp_a", A, 16'hFFFC);
        chk("scmp_fun", ALU_FUN, 3);
        CMP_OUT = 2'd1; CMP_Flag = 1'b1;
        step();
        CMP_Flag = 1'b0;
        chk("scmp_stale", rsp_valid, 0);
        chk("scmp_en1", ens, 4'b0100);
        step();
        chk("scmp_nv2", rsp_valid, 0);
        CMP_OUT = 2'd3; CMP_Flag = 1'b1;
        step();
        CMP_Flag = 1'b0;
        chk("scmp_valid", rsp_valid, 1);
        chk("scmp_data", rsp_data, 32'h00000003);
        step();

        // timeout, with a non-selected flag that must be ignored
        issue(4'b0001, 16'd1, 16'd2);
        Logic_Flag = 1'b1; Logic_OUT = 16'h5555;
        for (int i = 1; i < 8; i++) begin
            chk("tmo_en", ens, 4'b0001);
            chk("tmo_nv", rsp_valid, 0);
            step();
        end
        chk("tmo_en7", ens, 4'b0001);
        step();
        Logic_Flag = 1'b0;
        chk("tmo_en_off", ens, 0);
        chk("tmo_valid", rsp_valid, 1);
        chk("tmo_flag", rsp_timeout, 1);
        chk("tmo_data", rsp_data, 0);
        chk("tmo_unit", rsp_unit, 0);
        step();

        // flag on the same edge the counter expires
        issue(4'b0000, 16'd3, 16'd4);
        Arith_OUT = 32'h12345678;
        for (int i = 1; i < 8; i++) step();
        chk("race_nv", rsp_valid, 0);
        Arith_Flag = 1'b1;
        step();
        Arith_Flag = 1'b0;
        chk("race_valid", rsp_valid, 1);
        chk("race_tmo", rsp_timeout, 0);
        chk("race_data", rsp_data, 32'h12345678);
        step();

        // backpressure on the response
        rsp_ready = 1'b0;
        issue(4'b0100, 16'h00F0, 16'h0F0F);
        Logic_OUT = 16'h8001; Logic_Flag = 1'b1;
        step();
        step();
        Logic_Flag = 1'b0;
        chk("bp_valid", rsp_valid, 1);
        cmd_valid = 1'b1; cmd_fun = 4'b1100;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_v", rsp_valid, 1);
            chk("bp_hold_d", rsp_data, 32'h00008001);
            chk("bp_unit", rsp_unit, 1);
            chk("bp_busy", cmd_ready, 0);
            chk("bp_no_acc", ens, 0);
        end
        rsp_ready = 1'b1; cmd_valid = 1'b0;
        step();
        chk("bp_done", rsp_valid, 0);
        chk("bp_idle", cmd_ready, 1);
        chk("bp_en_idle", ens, 0);
        issue(4'b1100, 16'd8, 16'd1);
        chk("bp_next_acc", ens, 4'b1000);

        // reset while in WAIT
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rw_ready", cmd_ready, 1);
        chk("rw_en", ens, 0);
        chk("rw_nv", rsp_valid, 0);
        Shift_Flag = 1'b1;
        step();
        step();
        Shift_Flag = 1'b0;
        chk("rw_no_rsp", rsp_valid, 0);

        // reset while in RESP
        rsp_ready = 1'b0;
        issue(4'b0110, 16'd1, 16'd1);
        Logic_OUT = 16'h00AA; Logic_Flag = 1'b1;
        step();
        step();
        Logic_Flag = 1'b0;
        chk("rr_valid", rsp_valid, 1);
        chk("rr_data", rsp_data, 32'h000000AA);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rr_nv", rsp_valid, 0);
        chk("rr_ready", cmd_ready, 1);
        chk("rr_data0", rsp_data, 0);
        step();
        chk("rr_nv2", rsp_valid, 0);
        chk("rr_en", ens, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
